hazard_controller: RTL and testbench

//  Pipeline sequencer for the 5-stage RV32I core (IF/ID/EXE/MEM/WB).
//  - Holds a shadow pipeline of destination tags; drives the EXE-stage operand forwarding selects.
//  - Detects load-use and memory-wait hazards; generates per-stage stall and flush (bubble) controls.
//  - Inserts bubbles on taken branches/jumps resolved in EXE.
//  - Sits beside the datapath and is the only source of forward_a_sel/forward_b_sel.

---
 rtl/hazard_pkg.sv | 34 +++
 rtl/hazard_tag_stage.sv | 28 ++
 rtl/hazard_controller.sv | 123 ++++++++++++
 tb/tb_hazard_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared widths, forward-select codes, FSM state and shadow-tag types for the hazard controller.
package hazard_pkg;

  localparam int REG_AW = 5;
  localparam int FWD_W  = 2;

  localparam logic [FWD_W-1:0] FORWARD_SEL_EXE = 2'd0;
  localparam logic [FWD_W-1:0] FORWARD_SEL_MEM = 2'd1;
  localparam logic [FWD_W-1:0] FORWARD_SEL_WB  = 2'd2;

  typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT, FLUSH} haz_state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } stage_tag_t;

  // EXE also carries its sources so forwarding can be resolved there.
  typedef struct packed {
    stage_tag_t        tag;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
  } exe_tag_t;

  // A stage supplies register rs when it holds a live writer of it; x0 never matches.
  function automatic logic tag_hit(stage_tag_t t, logic [REG_AW-1:0] rs, logic used);
    return t.valid && t.reg_write && (t.rd != '0) && used && (t.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// One shadow pipeline stage register: holds on i_hold, loads an all-zero bubble on i_bubble.
module hazard_tag_stage #(
  parameter type T = hazard_pkg::stage_tag_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_hold,
  input  logic i_bubble,
  input  T     i_d,
  output T     o_q
);

  T r_q;
  T w_nxt;

  always_comb begin
    w_nxt = i_d;
    if (i_bubble) w_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)          r_q <= '0;
    else if (!i_hold) r_q <= w_nxt;
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_controller.sv
// RV32I 5-stage hazard sequencer: shadow tags, EXE forwarding selects, stall/flush control.
// Optional WB_FORWARD_EN: forward from WB; otherwise a MEM-stage writer dependency stalls ID one cycle.
module hazard_controller
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_id,
  input  logic [REG_AW-1:0] rs1_addr_id,
  input  logic              rs1_used_id,
  input  logic [REG_AW-1:0] rs2_addr_id,
  input  logic              rs2_used_id,
  input  logic [REG_AW-1:0] rd_addr_id,
  input  logic              reg_write_id,
  input  logic              mem_read_id,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_pipe,
  output logic              flush_id,
  output logic              flush_exe,
  output logic [FWD_W-1:0]  forward_a_sel,
  output logic [FWD_W-1:0]  forward_b_sel
);

  haz_state_t r_state, w_state_nxt;
  exe_tag_t   w_exe_d, w_exe;
  stage_tag_t w_mem, w_wb;
  logic       w_ld_use, w_mem_dep, w_branch;
  logic       w_unused;

  always_comb begin
    w_exe_d               = '0;
    w_exe_d.tag.valid     = valid_id;
    w_exe_d.tag.rd        = rd_addr_id;
    w_exe_d.tag.reg_write = reg_write_id;
    w_exe_d.tag.mem_read  = mem_read_id;
    w_exe_d.rs1           = rs1_addr_id;
    w_exe_d.rs2           = rs2_addr_id;
    w_exe_d.rs1_used      = rs1_used_id;
    w_exe_d.rs2_used      = rs2_used_id;
  end

  hazard_tag_stage #(.T(exe_tag_t)) u_exe (
    .clk(clk), .rst(rst), .i_hold(stall_pipe), .i_bubble(flush_exe),
    .i_d(w_exe_d), .o_q(w_exe)
  );

  hazard_tag_stage #(.T(stage_tag_t)) u_mem (
    .clk(clk), .rst(rst), .i_hold(stall_pipe), .i_bubble(1'b0),
    .i_d(w_exe.tag), .o_q(w_mem)
  );

  hazard_tag_stage #(.T(stage_tag_t)) u_wb (
    .clk(clk), .rst(rst), .i_hold(stall_pipe), .i_bubble(1'b0),
    .i_d(w_mem), .o_q(w_wb)
  );

  assign w_ld_use = valid_id && w_exe.tag.valid && w_exe.tag.mem_read && (w_exe.tag.rd != '0) &&
                    ((rs1_used_id && (rs1_addr_id == w_exe.tag.rd)) ||
                     (rs2_used_id && (rs2_addr_id == w_exe.tag.rd)));

`ifdef WB_FORWARD_EN
  assign w_mem_dep = 1'b0;
`else
  // No WB path: a consumer two behind its producer re-reads the write-through regfile instead.
  assign w_mem_dep = valid_id && (tag_hit(w_mem, rs1_addr_id, rs1_used_id) ||
                                  tag_hit(w_mem, rs2_addr_id, rs2_used_id));
`endif

  // EXE holds the bubble we just inserted during FLUSH, so it cannot redirect again.
  assign w_branch = branch_taken && (r_state != FLUSH);

  always_comb begin
    w_state_nxt = RUN;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_pipe  = 1'b0;
    flush_id    = 1'b0;
    flush_exe   = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        stall_if    = 1'b1;
        stall_id    = 1'b1;
        stall_pipe  = 1'b1;
        w_state_nxt = MEMWAIT;
      end else if (w_branch) begin
        flush_id    = 1'b1;
        flush_exe   = 1'b1;
        w_state_nxt = FLUSH;
      end else if (w_ld_use || w_mem_dep) begin
        stall_if    = 1'b1;
        stall_id    = 1'b1;
        flush_exe   = 1'b1;
        w_state_nxt = LDSTALL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    forward_a_sel = FORWARD_SEL_EXE;
    forward_b_sel = FORWARD_SEL_EXE;
    if (!rst) begin
      if (tag_hit(w_mem, w_exe.rs1, w_exe.rs1_used)) forward_a_sel = FORWARD_SEL_MEM;
`ifdef WB_FORWARD_EN
      else if (tag_hit(w_wb, w_exe.rs1, w_exe.rs1_used)) forward_a_sel = FORWARD_SEL_WB;
`endif
      if (tag_hit(w_mem, w_exe.rs2, w_exe.rs2_used)) forward_b_sel = FORWARD_SEL_MEM;
`ifdef WB_FORWARD_EN
      else if (tag_hit(w_wb, w_exe.rs2, w_exe.rs2_used)) forward_b_sel = FORWARD_SEL_WB;
`endif
    end
  end

  assign w_unused = ^w_wb;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed sequences plus random traffic against a stage-array model.
// Honours WB_FORWARD_EN the same way the design does.
module tb_hazard_controller;
  import hazard_pkg::*;

`ifdef WB_FORWARD_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       mr;
  } minst_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       branch_taken = 1'b0;
  logic       mem_busy = 1'b0;
  minst_t     id = '0;
  logic       stall_if, stall_id, stall_pipe, flush_id, flush_exe;
  logic [1:0] fa, fb;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk(clk), .rst(rst), .valid_id(id.v),
    .rs1_addr_id(id.rs1), .rs1_used_id(id.u1),
    .rs2_addr_id(id.rs2), .rs2_used_id(id.u2),
    .rd_addr_id(id.rd), .reg_write_id(id.we), .mem_read_id(id.mr),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .stall_if(stall_if), .stall_id(stall_id), .stall_pipe(stall_pipe),
    .flush_id(flush_id), .flush_exe(flush_exe),
    .forward_a_sel(fa), .forward_b_sel(fb)
  );

  // Model: pipe[0]=EXE, pipe[1]=MEM, pipe[2]=WB instruction records.
  minst_t     pipe [3];
  int         n_vec = 0;
  int         n_err = 0;
  logic [4:0] e_ctl = '0;  // {stall_if, stall_id, stall_pipe, flush_id, flush_exe}
  logic [1:0] e_fa = '0;
  logic [1:0] e_fb = '0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic reads(minst_t i, logic [4:0] r);
    return i.v && (r != 5'd0) && ((i.u1 && i.rs1 == r) || (i.u2 && i.rs2 == r));
  endfunction

  // Youngest older writer of rs decides where the operand comes from.
  function automatic logic [1:0] src_sel(logic [4:0] rs, logic used);
    if (!used || rs == 5'd0) return FORWARD_SEL_EXE;
    for (int s = 1; s <= 2; s++)
      if (pipe[s].v && pipe[s].we && pipe[s].rd == rs)
        return (s == 1) ? FORWARD_SEL_MEM : (WB_EN ? FORWARD_SEL_WB : FORWARD_SEL_EXE);
    return FORWARD_SEL_EXE;
  endfunction

  task automatic predict();
    logic lduse, memdep;
    e_ctl = '0;
    e_fa  = FORWARD_SEL_EXE;
    e_fb  = FORWARD_SEL_EXE;
    if (!rst) begin
      lduse  = pipe[0].v && pipe[0].mr && reads(id, pipe[0].rd);
      memdep = !WB_EN && pipe[1].v && pipe[1].we && reads(id, pipe[1].rd);
      if (mem_busy)             e_ctl = 5'b11100;
      else if (branch_taken)    e_ctl = 5'b00011;
      else if (lduse || memdep) e_ctl = 5'b11001;
      e_fa = src_sel(pipe[0].rs1, pipe[0].u1);
      e_fb = src_sel(pipe[0].rs2, pipe[0].u2);
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    predict();
    chk({tag, ":ctl"}, {3'b0, stall_if, stall_id, stall_pipe, flush_id, flush_exe}, {3'b0, e_ctl});
    chk({tag, ":fwd_a"}, {6'b0, fa}, {6'b0, e_fa});
    chk({tag, ":fwd_b"}, {6'b0, fb}, {6'b0, e_fb});
    @(posedge clk);
    if (rst) begin
      for (int s = 0; s < 3; s++) pipe[s] = '0;
    end else if (!e_ctl[2]) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e_ctl[0] ? minst_t'('0) : id;
    end
    #1;
  endtask

  function automatic minst_t alu(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    minst_t m = '0;
    m.v = 1'b1; m.rd = rd; m.rs1 = rs1; m.rs2 = rs2; m.u1 = 1'b1; m.u2 = 1'b1; m.we = 1'b1;
    return m;
  endfunction

  function automatic minst_t ld(logic [4:0] rd, logic [4:0] rs1);
    minst_t m = '0;
    m.v = 1'b1; m.rd = rd; m.rs1 = rs1; m.u1 = 1'b1; m.we = 1'b1; m.mr = 1'b1;
    return m;
  endfunction

  function automatic minst_t rnd_inst();
    minst_t m = '0;
    m.v   = ($urandom_range(0, 7) != 0);
    m.rs1 = 5'($urandom_range(0, 3));
    m.rs2 = 5'($urandom_range(0, 3));
    m.rd  = 5'($urandom_range(0, 3));
    m.u1  = 1'($urandom_range(0, 1));
    m.u2  = 1'($urandom_range(0, 1));
    m.mr  = ($urandom_range(0, 3) == 0);
    m.we  = m.mr | 1'($urandom_range(0, 1));
    return m;
  endfunction

  // Present one instruction in ID and re-present it while ID is stalled.
  task automatic run(input string tag, input minst_t ins);
    int n = 0;
    id = ins;
    cycle(tag);
    while (e_ctl[3] && n < 20) begin
      cycle(tag);
      n++;
    end
    if (n >= 20) chk({tag, ":timeout"}, 8'd1, 8'd0);
  endtask

  task automatic drain();
    repeat (3) run("drain", alu(5'd0, 5'd0, 5'd0));
  endtask

  initial begin
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    @(posedge clk); #1;
    repeat (2) cycle("reset");
    rst = 1'b0;

    // back-to-back dependency -> MEM forward
    run("t1", alu(5'd5, 5'd1, 5'd2));
    run("t1", alu(5'd6, 5'd5, 5'd1));
    drain();
    // distance-two dependency -> WB forward or one stall
    run("t2", alu(5'd5, 5'd1, 5'd2));
    run("t2", alu(5'd0, 5'd0, 5'd0));
    run("t2", alu(5'd7, 5'd1, 5'd5));
    drain();
    // load-use
    run("t3", ld(5'd5, 5'd1));
    run("t3", alu(5'd6, 5'd5, 5'd5));
    drain();
    // taken branch overrides a load-use pair
    run("t4", ld(5'd5, 5'd1));
    id = alu(5'd6, 5'd5, 5'd5);
    branch_taken = 1'b1;
    cycle("t4_br");
    branch_taken = 1'b0;
    id = '0;
    cycle("t4_post");
    drain();
    // branch held under mem_busy, flushes on first free cycle
    run("t5", alu(5'd9, 5'd1, 5'd2));
    id = alu(5'd3, 5'd9, 5'd9);
    branch_taken = 1'b1;
    mem_busy = 1'b1;
    repeat (3) cycle("t5_busy");
    mem_busy = 1'b0;
    cycle("t5_flush");
    branch_taken = 1'b0;
    id = '0;
    cycle("t5_post");
    drain();
    // x0 is never a hazard source
    run("t6", alu(5'd0, 5'd1, 5'd2));
    run("t6", alu(5'd3, 5'd0, 5'd0));
    drain();
    // reset during a memory stall and during a load-use stall
    mem_busy = 1'b1;
    cycle("t6_busy");
    rst = 1'b1;
    cycle("t6_rst");
    rst = 1'b0;
    mem_busy = 1'b0;
    cycle("t6_idle");
    run("t6", ld(5'd4, 5'd1));
    id = alu(5'd2, 5'd4, 5'd0);
    cycle("t6_ld");
    rst = 1'b1;
    cycle("t6_rst2");
    rst = 1'b0;
    cycle("t6_idle2");
    drain();

    // random traffic with realistic ID hold/flush and held branches
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (!e_ctl[3]) id = e_ctl[1] ? minst_t'('0) : rnd_inst();
      if (!(branch_taken && e_ctl[2] && pipe[0].v))
        branch_taken = pipe[0].v && ($urandom_range(0, 6) == 0);
      mem_busy = ($urandom_range(0, 3) == 0);
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
